// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one carry-select adder among NREQ requesters, with
// per-requester locking so multi-word additions can chain the stored carry.
module adder_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic [NREQ-1:0]       cin_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  output logic [IdW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic                  res_chained,
  output logic                  busy
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   owner_q, owner_d;
  logic             carry_q, carry_d;

  logic             res_valid_q;
  logic [IdW-1:0]   res_id_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;
  logic             res_chained_q;

  logic             idle_found;
  logic [IdW-1:0]   idle_idx;
  logic [IdW-1:0]   cand_idx;
  logic [IdW-1:0]   gnt_idx;
  logic             xfer;
  logic [IdW-1:0]   next_ptr;

  logic [WIDTH-1:0] op_a, op_b;
  logic             cin_eff;
  logic [WIDTH:0]   chain0, chain1;
  logic [WIDTH-1:0] sum0, sum1;
  logic [WIDTH-1:0] sum_sel;
  logic             cout_sel;

  // Idle arbitration: first requester at or above ptr_q, wrapping around.
  always_comb begin
    idle_found = 1'b0;
    idle_idx   = '0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_idx = IdW'((32'(ptr_q) + k) % NREQ);
      if (!idle_found && req[cand_idx]) begin
        idle_found = 1'b1;
        idle_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (!rst_n) begin
      gnt = '0;
    end else if (state_q == StLocked) begin
      gnt_idx = owner_q;
      if (req[owner_q]) begin
        gnt[owner_q] = 1'b1;
      end
    end else if (idle_found) begin
      gnt_idx       = idle_idx;
      gnt[idle_idx] = 1'b1;
    end
  end

  assign xfer     = |gnt;
  assign next_ptr = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign op_a    = a_in[32'(gnt_idx) * WIDTH +: WIDTH];
  assign op_b    = b_in[32'(gnt_idx) * WIDTH +: WIDTH];
  assign cin_eff = (state_q == StLocked) ? carry_q : cin_in[gnt_idx];

  // Carry-select: both ripple chains run in parallel, the effective carry picks one.
  always_comb begin
    chain0[0] = 1'b0;
    chain1[0] = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum0[i]     = op_a[i] ^ op_b[i] ^ chain0[i];
      sum1[i]     = op_a[i] ^ op_b[i] ^ chain1[i];
      chain0[i+1] = (op_a[i] & op_b[i]) | (chain0[i] & (op_a[i] ^ op_b[i]));
      chain1[i+1] = (op_a[i] & op_b[i]) | (chain1[i] & (op_a[i] ^ op_b[i]));
    end
  end

  assign sum_sel  = cin_eff ? sum1 : sum0;
  assign cout_sel = cin_eff ? chain1[WIDTH] : chain0[WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    carry_d = carry_q;
    if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (lock[gnt_idx]) begin
            state_d = StLocked;
            owner_d = gnt_idx;
            carry_d = cout_sel;
          end else begin
            ptr_d = next_ptr;
          end
        end
        StLocked: begin
          carry_d = cout_sel;
          if (!lock[owner_q]) begin
            state_d = StIdle;
            ptr_d   = next_ptr;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_sum_q     <= '0;
      res_cout_q    <= 1'b0;
      res_chained_q <= 1'b0;
    end else begin
      res_valid_q <= xfer;
      if (xfer) begin
        res_id_q      <= gnt_idx;
        res_sum_q     <= sum_sel;
        res_cout_q    <= cout_sel;
        res_chained_q <= (state_q == StLocked);
      end
    end
  end

  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_sum     = res_sum_q;
  assign res_cout    = res_cout_q;
  assign res_chained = res_chained_q;
  assign busy        = (state_q == StLocked);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter against a behavioural arbitration/adder model.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req, lock, cin_in;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   gnt;
  logic           res_valid, res_cout, res_chained, busy;
  logic [1:0]     res_id;
  logic [W-1:0]   res_sum;

  adder_share_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .lock       (lock),
    .a_in       (a_in),
    .b_in       (b_in),
    .cin_in     (cin_in),
    .gnt        (gnt),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_chained(res_chained),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  bit m_carry;
  bit exp_valid, exp_cout, exp_chained;
  int exp_id;
  logic [W-1:0] exp_sum;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_carry = 0;
    exp_valid = 0; exp_id = 0; exp_sum = '0; exp_cout = 0; exp_chained = 0;
  endtask

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r);
    logic [N-1:0] g;
    g = '0;
    if (m_locked) begin
      if (r[m_owner]) g[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (r[i]) begin
          g[i] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  function automatic logic [N*W-1:0] put(input int slot, input logic [W-1:0] v);
    logic [N*W-1:0] x;
    x = {$urandom, $urandom};
    x[slot*W +: W] = v;
    return x;
  endfunction

  task automatic check_results();
    check_val("res_valid", res_valid, exp_valid);
    check_val("res_id", res_id, exp_id);
    check_val("res_sum", res_sum, exp_sum);
    check_val("res_cout", res_cout, exp_cout);
    check_val("res_chained", res_chained, exp_chained);
    check_val("busy", busy, m_locked);
  endtask

  // Entered at posedge+1; drives one cycle, checks grant, clocks, checks result.
  task automatic do_cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] c,
                          input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    logic [N-1:0] eg;
    logic [W:0]   full;
    int           gi;
    bit           eff;
    req = r; lock = l; cin_in = c; a_in = a; b_in = b;
    #1;
    eg = model_gnt(r);
    check_val("gnt", gnt, eg);
    check_val("busy_pre", busy, m_locked);
    @(posedge clk);
    #1;
    if (eg != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (eg[i]) gi = i;
      eff  = m_locked ? m_carry : c[gi];
      full = {1'b0, a[gi*W +: W]} + {1'b0, b[gi*W +: W]} + (W+1)'(eff);
      exp_valid = 1; exp_id = gi; exp_sum = full[W-1:0]; exp_cout = full[W];
      exp_chained = m_locked;
      if (m_locked) begin
        m_carry = full[W];
        if (!l[gi]) begin
          m_locked = 0;
          m_ptr    = (gi + 1) % N;
        end
      end else if (l[gi]) begin
        m_locked = 1;
        m_owner  = gi;
        m_carry  = full[W];
      end else begin
        m_ptr = (gi + 1) % N;
      end
    end else begin
      exp_valid = 0;
    end
    check_results();
  endtask

  initial begin
    logic [N-1:0] r, l;
    logic [N*W-1:0] a, b;
    model_reset();
    rst_n = 1'b0; req = '1; lock = '0; cin_in = '0; a_in = '0; b_in = '0;
    #3;
    check_val("gnt_in_reset", gnt, 0);
    req = '0;
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_results();

    // Single request
    do_cycle(4'b0001, 4'b0000, 4'b0000, put(0, 16'h1234), put(0, 16'h4321));
    check_val("plan_sum5555", res_sum, 16'h5555);

    // Round-robin fairness
    for (int i = 0; i < 8; i++)
      do_cycle(4'b1111, 4'b0000, 4'(($urandom)), {$urandom, $urandom}, {$urandom, $urandom});

    // 32-bit chained add via requester 2
    do_cycle(4'b0100, 4'b0100, 4'b0000, put(2, 16'hFFFF), put(2, 16'h0001));
    check_val("chain_w0_sum", res_sum, 16'h0000);
    check_val("chain_w0_cout", res_cout, 1);
    check_val("chain_w0_busy", busy, 1);
    do_cycle(4'b0100, 4'b0000, 4'b0000, put(2, 16'h0001), put(2, 16'h0002));
    check_val("chain_w1_sum", res_sum, 16'h0004);
    check_val("chain_w1_chained", res_chained, 1);
    do_cycle(4'b1111, 4'b0000, 4'b0000, {$urandom, $urandom}, {$urandom, $urandom});
    check_val("ptr_after_chain", res_id, 3);

    // Lock exclusion with owner request dropped
    do_cycle(4'b0010, 4'b0010, 4'b0000, put(1, 16'hFFFF), put(1, 16'hFFFF));
    for (int i = 0; i < 3; i++)
      do_cycle(4'b1101, 4'b0010, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom});
    do_cycle(4'b1111, 4'b0000, 4'b0000, put(1, 16'h0000), put(1, 16'h0000));
    check_val("excl_carry_held", res_sum, 16'h0001);

    // Carry-in select
    do_cycle(4'b0001, 4'b0000, 4'b0001, put(0, 16'h7FFF), put(0, 16'h8000));
    check_val("cin1_sum", res_sum, 16'h0000);
    do_cycle(4'b0001, 4'b0000, 4'b0000, put(0, 16'h7FFF), put(0, 16'h8000));
    check_val("cin0_sum", res_sum, 16'hFFFF);

    // Async reset mid-lock
    do_cycle(4'b0100, 4'b0100, 4'b0000, put(2, 16'hFFFF), put(2, 16'hFFFF));
    req = 4'b0100; lock = 4'b0100;
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", res_valid, 0);
    check_val("rst_gnt", gnt, 0);
    model_reset();
    req = '0; lock = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_results();
    do_cycle(4'b1000, 4'b0000, 4'b0000, {$urandom, $urandom}, {$urandom, $urandom});
    check_val("post_rst_chained", res_chained, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      l = 4'($urandom) & 4'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = '1;
      do_cycle(r, l, 4'($urandom), a, b);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
